// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and FSM encodings for the memory-mapped UART.
package uart_mmio_pkg;

    localparam int unsigned OFF_BAUD   = 0;
    localparam int unsigned OFF_CTRL   = 1;
    localparam int unsigned OFF_STATUS = 2;
    localparam int unsigned OFF_TXDATA = 3;
    localparam int unsigned OFF_RXDATA = 4;

    localparam int unsigned CTRL_TX_EN = 0;
    localparam int unsigned CTRL_RX_EN = 1;
    localparam int unsigned CTRL_LOOP  = 2;
    localparam int unsigned CTRL_FLUSH = 3;
    localparam int unsigned CTRL_RX_IE = 4;
    localparam int unsigned CTRL_TX_IE = 5;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_TX_BUSY  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_RX_FULL  = 4;
    localparam int unsigned ST_RX_OVR   = 5;
    localparam int unsigned ST_FRAME    = 6;
    localparam int unsigned ST_TX_OVF   = 7;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is ignored even if a pop
// happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: register file, TX/RX FIFOs, baud-timed TX and RX framers,
// sticky error flags, registered interrupt and bus stall on a full TX FIFO.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned BASE_ADDR     = 20,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned BAUD_W        = 16,
    parameter int unsigned BAUD_RESET    = 15,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned STALL_ON_FULL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              hit,
    output logic              stall,
    output logic              irq,
    input  logic              rx,
    output logic              tx
);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0]    off;
    logic                 wr, rd, sel_baud, sel_ctrl, sel_status, sel_tx, sel_rx;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [5:0]           ctrl_q, ctrl_d;
    logic                 ovr_q, ovr_d, ferr_q, ferr_d, tovf_q, tovf_d, irq_q, irq_d;
    logic [2:0]           clr;
    logic [7:0]           status;
    logic                 flush, tx_push, tx_drop, rx_pop;
    logic                 tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic [CW-1:0]        tx_count, rx_count;

    tx_state_e            tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_q, tx_d, tx_pop;

    rx_state_e            rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]    rx_cnt_q, rx_cnt_d, rx_half;
    logic [BAUD_W:0]      rx_half_full;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_in;
    logic                 rx_push, ovr_set, ferr_set;
    logic                 unused_sigs;

    assign off        = addr - ADDR_W'(BASE_ADDR);
    assign hit        = (addr >= ADDR_W'(BASE_ADDR)) && (addr <= ADDR_W'(BASE_ADDR + 4)) && (re || we);
    assign wr         = hit && we;
    assign rd         = hit && re;
    assign sel_baud   = (off == ADDR_W'(OFF_BAUD));
    assign sel_ctrl   = (off == ADDR_W'(OFF_CTRL));
    assign sel_status = (off == ADDR_W'(OFF_STATUS));
    assign sel_tx     = (off == ADDR_W'(OFF_TXDATA));
    assign sel_rx     = (off == ADDR_W'(OFF_RXDATA));

    assign flush   = wr && sel_ctrl && wdata[CTRL_FLUSH];
    assign stall   = wr && sel_tx && tx_full && (STALL_ON_FULL != 0);
    assign tx_push = wr && sel_tx && !tx_full;
    assign tx_drop = wr && sel_tx && tx_full && (STALL_ON_FULL == 0);
    assign rx_pop  = rd && sel_rx;
    assign clr     = (wr && sel_status) ? wdata[7:5] : 3'b000;
    assign rx_in   = ctrl_q[CTRL_LOOP] ? tx_q : rx_sync_q;
    assign tx      = tx_q;
    assign irq     = irq_q;
    assign unused_sigs = ^{wdata, tx_count, rx_count};

    // RX waits (divisor+1)/2 clocks after the falling edge before sampling the start bit.
    assign rx_half_full = ({1'b0, baud_q} + (BAUD_W+1)'(1)) >> 1;
    assign rx_half      = (rx_half_full == '0) ? '0 : BAUD_W'(rx_half_full - (BAUD_W+1)'(1));

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
        .wdata(wdata[DATA_BITS-1:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(flush),
        .wdata(rx_sh_q), .rdata(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_BUSY]  = (tx_state_q != TxIdle);
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_OVR]   = ovr_q;
        status[ST_FRAME]    = ferr_q;
        status[ST_TX_OVF]   = tovf_q;

        rdata = '0;
        if (hit) begin
            if (sel_baud)        rdata = 32'(baud_q);
            else if (sel_ctrl)   rdata = 32'(ctrl_q);
            else if (sel_status) rdata = 32'(status);
            else if (sel_rx)     rdata = rx_empty ? 32'd0 : 32'(rx_head);
        end

        baud_d = (wr && sel_baud) ? wdata[BAUD_W-1:0] : baud_q;
        ctrl_d = (wr && sel_ctrl) ? {wdata[5:4], 1'b0, wdata[2:0]} : ctrl_q;
        ovr_d  = (ovr_q  && !clr[0]) || ovr_set;
        ferr_d = (ferr_q && !clr[1]) || ferr_set;
        tovf_d = (tovf_q && !clr[2]) || tx_drop;
        irq_d  = (ctrl_q[CTRL_RX_IE] && !rx_empty)
              || (ctrl_q[CTRL_TX_IE] && tx_empty && (tx_state_q == TxIdle))
              || ovr_q || ferr_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                    tx_pop = 1'b1; tx_sh_d = tx_head; tx_cnt_d = baud_q;
                    tx_d = 1'b0; tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxData; tx_cnt_d = baud_q; tx_bit_d = '0; tx_d = tx_sh_q[0];
                end else tx_cnt_d = tx_cnt_q - BAUD_W'(1);
            end
            TxData: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = baud_q;
                    if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                        tx_state_d = TxStop; tx_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1); tx_sh_d = tx_sh_q >> 1; tx_d = tx_sh_q[1];
                    end
                end else tx_cnt_d = tx_cnt_q - BAUD_W'(1);
            end
            TxStop: begin
                if (tx_cnt_q == '0) begin
                    if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                        tx_pop = 1'b1; tx_sh_d = tx_head; tx_cnt_d = baud_q;
                        tx_d = 1'b0; tx_state_d = TxStart;
                    end else tx_state_d = TxIdle;
                end else tx_cnt_d = tx_cnt_q - BAUD_W'(1);
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        if (!ctrl_q[CTRL_RX_EN]) begin
            rx_state_d = RxIdle;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (!rx_in && rx_prev_q) begin
                        rx_state_d = RxStart; rx_cnt_d = rx_half;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_d = rx_in ? RxIdle : RxData;
                        rx_cnt_d = baud_q; rx_bit_d = '0;
                    end else rx_cnt_d = rx_cnt_q - BAUD_W'(1);
                end
                RxData: begin
                    if (rx_cnt_q == '0) begin
                        rx_sh_d  = {rx_in, rx_sh_q[DATA_BITS-1:1]};
                        rx_cnt_d = baud_q;
                        if (rx_bit_q == BIT_W'(DATA_BITS - 1)) rx_state_d = RxStop;
                        else rx_bit_d = rx_bit_q + BIT_W'(1);
                    end else rx_cnt_d = rx_cnt_q - BAUD_W'(1);
                end
                RxStop: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_d = RxIdle;
                        if (!rx_in)       ferr_set = 1'b1;
                        else if (rx_full) ovr_set  = 1'b1;
                        else              rx_push  = 1'b1;
                    end else rx_cnt_d = rx_cnt_q - BAUD_W'(1);
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_q     <= BAUD_W'(BAUD_RESET);
            ctrl_q     <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tovf_q     <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            baud_q     <= baud_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            tovf_q     <= tovf_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_in;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus tasks, a serial TX decoder and
// scoreboards of expected TX frames and RX bytes.
module tb_uart_mmio;
    localparam int BASE = 20;
    localparam int BIT  = 4;   // bit period with BAUD=3

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] rdata;
    logic        hit, stall, irq, tx;

    int n_cmp = 0;
    int n_bad = 0;
    int last_stalls = 0;
    bit mon_en = 1'b0;
    bit mon_contig = 1'b0;
    int mon_frames = 0;
    int mon_idle = 0;
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];

    uart_mmio dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .hit(hit), .stall(stall), .irq(irq), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        addr = 32'(BASE + off); wdata = d; we = 1'b1;
        #1;
        while (stall === 1'b1 && n < 1000) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        we = 1'b0; addr = '0;
        last_stalls = n;
        if (n >= 1000) check_eq("stall_bound", n, 0);
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        @(negedge clk);
        addr = 32'(BASE + off); re = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1;
        re = 1'b0; addr = '0;
    endtask

    task automatic wait_tx_drain(input int max);
        int n = 0;
        while ((tx_sb.size() != 0 || tx !== 1'b1) && n < max) begin
            @(negedge clk); n++;
        end
        check_eq("tx_drain_in_time", n < max, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk); rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
    endtask

    // Decodes frames on tx by sampling each bit at its middle.
    always begin : tx_monitor
        logic [7:0] b;
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin
            if (mon_contig && mon_frames > 0) check_eq("tx_no_idle_gap", mon_idle, 1);
            repeat (BIT / 2) @(negedge clk);
            check_eq("tx_start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            check_eq("tx_stop_bit", tx, 1);
            if (tx_sb.size() == 0) check_eq("tx_unexpected_frame", b, 32'hffff_ffff);
            else check_eq("tx_frame", b, tx_sb.pop_front());
            mon_frames++;
            mon_idle = 0;
        end else if (tx === 1'b1) begin
            mon_idle++;
        end
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          n;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx", tx, 1);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_irq", irq, 0);
        rst = 1'b1;
        bus_read(0, d); check_eq("rst_baud", d, 15);
        bus_read(1, d); check_eq("rst_ctrl", d, 0);
        bus_read(2, d); check_eq("rst_status", d, 32'h0a);
        @(negedge clk); addr = 32'(BASE + 5); re = 1'b1; #1;
        check_eq("miss_hit", hit, 0);
        check_eq("miss_rdata", rdata, 0);
        addr = 32'(BASE + 4); #1;
        check_eq("edge_hit", hit, 1);
        check_eq("rxdata_empty", rdata, 0);
        @(negedge clk); re = 1'b0; addr = '0;
        bus_write(1, 32'h3f);
        bus_read(1, d); check_eq("ctrl_flush_reads_0", d, 32'h37);
        check_eq("irq_tx_idle", irq, 1);
        bus_write(1, 32'h00);
        repeat (2) @(negedge clk);
        check_eq("irq_off", irq, 0);

        // 2: loopback single frame
        bus_write(0, 3);
        bus_write(1, 32'h07);
        mon_en = 1'b1;
        tx_sb.push_back(8'ha5); rx_sb.push_back(8'ha5);
        bus_write(3, 32'ha5);
        check_eq("tx_high_at_push", tx, 1);
        @(posedge clk); #1;
        check_eq("tx_start_next_clk", tx, 0);
        n = 0;
        do begin
            bus_read(2, d); n++;
        end while (d[3] == 1'b1 && n < 100);
        check_eq("rx_arrival", n < 100, 1);
        bus_read(4, d); check_eq("rx_loop_byte", d, rx_sb.pop_front());
        bus_read(2, d); check_eq("rx_empty_after_pop", d[3], 1);
        wait_tx_drain(200);

        // 3: back-to-back frames, stall on full TX FIFO
        bus_write(1, 32'h01);
        mon_contig = 1'b1; mon_frames = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            tx_sb.push_back(b);
            bus_write(3, 32'(b));
            if (i < 9) check_eq("no_stall_before_full", last_stalls, 0);
            else check_eq("stall_when_full", last_stalls > 0, 1);
        end
        bus_read(2, d); check_eq("status_tx_full", d, 32'h0d);
        wait_tx_drain(800);
        check_eq("frames_sent", mon_frames, 10);
        mon_contig = 1'b0;

        // 4: loopback overrun
        bus_write(1, 32'h07);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            tx_sb.push_back(b);
            if (i < 8) rx_sb.push_back(b);
            bus_write(3, 32'(b));
        end
        wait_tx_drain(800);
        repeat (10) @(negedge clk);
        bus_read(2, d); check_eq("status_overrun", d, 32'h32);
        check_eq("irq_overrun", irq, 1);
        for (int i = 0; i < 8; i++) begin
            bus_read(4, d); check_eq("rx_order", d, rx_sb.pop_front());
        end
        bus_write(2, 32'h20);
        bus_read(2, d); check_eq("overrun_cleared", d, 32'h0a);
        check_eq("irq_after_clear", irq, 0);
        mon_en = 1'b0;

        // 5: external rx: framing error, good frame, glitch
        bus_write(1, 32'h02);
        send_rx(8'h55, 1'b0);
        bus_read(2, d); check_eq("status_frame_err", d, 32'h4a);
        check_eq("irq_frame_err", irq, 1);
        bus_write(2, 32'h40);
        bus_read(2, d); check_eq("frame_err_cleared", d, 32'h0a);
        send_rx(8'h3c, 1'b1);
        bus_read(4, d); check_eq("rx_ext_byte", d, 32'h3c);
        @(negedge clk); rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(2, d); check_eq("glitch_ignored", d, 32'h0a);
        check_eq("irq_glitch", irq, 0);

        // 6: reset mid-frame
        bus_write(1, 32'h07);
        bus_write(3, 32'h3c);
        bus_write(3, 32'hc3);
        repeat (15) @(negedge clk);
        check_eq("midframe_busy", tx === 1'b0 || tx === 1'b1, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_tx", tx, 1);
        rst = 1'b1;
        bus_read(1, d); check_eq("rst_mid_ctrl", d, 0);
        bus_read(0, d); check_eq("rst_mid_baud", d, 15);
        bus_read(2, d); check_eq("rst_mid_status", d, 32'h0a);
        repeat (60) @(negedge clk);
        bus_read(2, d); check_eq("no_residual_push", d, 32'h0a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
